// File: rtl/draw_scheduler.sv
// draw_scheduler: arbitrates three drawing engines (one clear engine, two
// sprite engines) onto a single VGA pixel port. One engine owns the port at a
// time; a watchdog bounds how long an owner may hold it.
//
// Engine handshake: draw_start[i] is a level held high for the whole grant.
// The engine raises eng_done[i] when it has finished and holds it until it
// sees draw_start[i] fall. The scheduler waits in RELEASE for that eng_done[i]
// to drop before it arbitrates again, so a stale done can never finish the
// next grant early.
module draw_scheduler #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int TIMEOUT  = 32768
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [2:0]  eng_done,
    input  logic [2:0]  eng_colour0,
    input  logic [2:0]  eng_colour1,
    input  logic [2:0]  eng_colour2,
    input  logic [10:0] eng_x0,
    input  logic [10:0] eng_x1,
    input  logic [10:0] eng_x2,
    input  logic [10:0] eng_y0,
    input  logic [10:0] eng_y1,
    input  logic [10:0] eng_y2,
    output logic [2:0]  draw_start,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        plot,
    output logic        busy,
    output logic [2:0]  done_pulse,
    output logic        timeout,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DRAW    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    // Watchdog is at least 16 bits, wider if TIMEOUT needs it.
    localparam int WD_W = ($clog2(TIMEOUT + 1) > 16) ? $clog2(TIMEOUT + 1) : 16;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [1:0]      grant_q, grant_d;
    logic            rr_q, rr_d;            // 0: engine 1 preferred, 1: engine 2 preferred
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic [2:0]      draw_start_q, draw_start_d;

    logic [10:0]     sel_x;
    logic [10:0]     sel_y;
    logic [2:0]      sel_colour;
    logic            sel_done;
    logic            in_bounds;
    logic [1:0]      win;
    logic            done_hit;
    logic            wd_hit;

    function automatic logic [2:0] onehot(input logic [1:0] g);
        case (g)
            2'd0:    onehot = 3'b001;
            2'd1:    onehot = 3'b010;
            2'd2:    onehot = 3'b100;
            default: onehot = 3'b000;
        endcase
    endfunction

    // Select the granted engine's pixel and done signal.
    always_comb begin
        sel_x      = eng_x0;
        sel_y      = eng_y0;
        sel_colour = eng_colour0;
        sel_done   = eng_done[0];
        case (grant_q)
            2'd1: begin
                sel_x      = eng_x1;
                sel_y      = eng_y1;
                sel_colour = eng_colour1;
                sel_done   = eng_done[1];
            end
            2'd2: begin
                sel_x      = eng_x2;
                sel_y      = eng_y2;
                sel_colour = eng_colour2;
                sel_done   = eng_done[2];
            end
            default: ;
        endcase
    end

    // Bounds test on the full 11-bit coordinates so off-screen parking never aliases on-screen.
    always_comb begin
        in_bounds = (sel_x < 11'(SCREEN_W)) && (sel_y < 11'(SCREEN_H));
    end

    // Arbitration: clear engine wins outright; sprites alternate when both ask.
    always_comb begin
        win = 2'd0;
        if (req[0]) begin
            win = 2'd0;
        end else if (req[1] && req[2]) begin
            win = rr_q ? 2'd2 : 2'd1;
        end else if (req[1]) begin
            win = 2'd1;
        end else begin
            win = 2'd2;
        end
    end

    // Next-state logic for the grant FSM, watchdog and round-robin pointer.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_d         = rr_q;
        wdog_d       = wdog_q;
        draw_start_d = draw_start_q;
        done_hit     = 1'b0;
        wd_hit       = 1'b0;
        case (state_q)
            S_IDLE: begin
                draw_start_d = 3'b000;
                if (req != 3'b000) begin
                    state_d      = S_DRAW;
                    grant_d      = win;
                    wdog_d       = '0;
                    draw_start_d = onehot(win);
                    // Only sprite grants move the pointer; clear grants leave it alone.
                    if (win != 2'd0) begin
                        rr_d = (win == 2'd1);
                    end
                end
            end
            S_DRAW: begin
                if (sel_done) begin
                    // Done takes priority over a watchdog expiry in the same cycle.
                    state_d      = S_RELEASE;
                    draw_start_d = 3'b000;
                    done_hit     = 1'b1;
                end else if (wdog_q == WD_LAST) begin
                    state_d      = S_RELEASE;
                    draw_start_d = 3'b000;
                    wd_hit       = 1'b1;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            S_RELEASE: begin
                draw_start_d = 3'b000;
                if (!sel_done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d      = S_IDLE;
                draw_start_d = 3'b000;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            grant_q      <= 2'd0;
            rr_q         <= 1'b0;
            wdog_q       <= '0;
            draw_start_q <= 3'b000;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_q         <= rr_d;
            wdog_q       <= wdog_d;
            draw_start_q <= draw_start_d;
        end
    end

    // Output decode: pixel port mirrors the owner only while drawing.
    always_comb begin
        draw_start = draw_start_q;
        busy       = (state_q != S_IDLE);
        dbg_state  = state_q;
        vga_x      = 8'd0;
        vga_y      = 7'd0;
        vga_colour = 3'd0;
        plot       = 1'b0;
        if (state_q == S_DRAW) begin
            vga_x      = sel_x[7:0];
            vga_y      = sel_y[6:0];
            vga_colour = sel_colour;
            plot       = !sel_done && in_bounds;
        end
        // Strobes mark the DRAW->RELEASE transition cycle; a reset in that cycle suppresses them.
        done_pulse = (done_hit && !reset) ? onehot(grant_q) : 3'b000;
        timeout    = wd_hit && !reset;
    end

endmodule

// File: tb/tb_draw_scheduler.sv
// Bench for draw_scheduler: directed scenarios feed expected grant and
// completion queues; a negedge monitor pops and compares whenever the DUT
// starts a grant or emits a completion/timeout strobe.
module tb_draw_scheduler;

    localparam int TO = 20000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req = 3'b000;
    logic [2:0]  eng_done = 3'b000;
    logic [2:0]  eng_colour0 = 3'd0;
    logic [2:0]  eng_colour1 = 3'd0;
    logic [2:0]  eng_colour2 = 3'd0;
    logic [10:0] eng_x0 = 11'd0;
    logic [10:0] eng_x1 = 11'd0;
    logic [10:0] eng_x2 = 11'd0;
    logic [10:0] eng_y0 = 11'd0;
    logic [10:0] eng_y1 = 11'd0;
    logic [10:0] eng_y2 = 11'd0;
    logic [2:0]  draw_start;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        plot;
    logic        busy;
    logic [2:0]  done_pulse;
    logic        timeout;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad = 0;
    int plot_cnt = 0;
    int n = 0;

    logic [2:0] exp_grant_q[$];
    logic [3:0] exp_end_q[$];
    logic [2:0] prev_ds = 3'b000;
    logic [2:0] rr_exp [4] = '{3'b010, 3'b100, 3'b010, 3'b100};

    draw_scheduler #(
        .SCREEN_W(160),
        .SCREEN_H(120),
        .TIMEOUT (TO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .eng_done   (eng_done),
        .eng_colour0(eng_colour0),
        .eng_colour1(eng_colour1),
        .eng_colour2(eng_colour2),
        .eng_x0     (eng_x0),
        .eng_x1     (eng_x1),
        .eng_x2     (eng_x2),
        .eng_y0     (eng_y0),
        .eng_y1     (eng_y1),
        .eng_y2     (eng_y2),
        .draw_start (draw_start),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .plot       (plot),
        .busy       (busy),
        .done_pulse (done_pulse),
        .timeout    (timeout),
        .dbg_state  (dbg_state)
    );

    // Clock
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int cycles);
        repeat (cycles) @(posedge clock);
        #1;
    endtask

    // Wait (bounded) for a grant to appear on draw_start.
    task automatic wait_grant();
        int k;
        k = 0;
        while (draw_start == 3'b000 && k < 10) begin
            tick(1);
            k++;
        end
        chk("grant_wait_busy", {31'd0, busy}, 32'd1);
    endtask

    // Scoreboard monitor: grants and completion strobes.
    always @(negedge clock) begin
        if (draw_start != 3'b000 && prev_ds == 3'b000) begin
            if (exp_grant_q.size() == 0) chk("grant_unexpected", {29'd0, draw_start}, 32'd0);
            else chk("grant", {29'd0, draw_start}, {29'd0, exp_grant_q.pop_front()});
        end
        if (done_pulse != 3'b000 || timeout) begin
            if (exp_end_q.size() == 0) chk("strobe_unexpected", {28'd0, timeout, done_pulse}, 32'd0);
            else chk("strobe", {28'd0, timeout, done_pulse}, {28'd0, exp_end_q.pop_front()});
        end
        prev_ds <= draw_start;
    end

    // Global time bound
    initial begin
        #1500000;
        bad++;
        $display("FAIL global_time_limit: got expired expected finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        // Reset state
        reset = 1'b1;
        tick(2);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_draw_start", {29'd0, draw_start}, 32'd0);
        chk("reset_plot", {31'd0, plot}, 32'd0);
        chk("reset_done_pulse", {29'd0, done_pulse}, 32'd0);
        chk("reset_timeout", {31'd0, timeout}, 32'd0);
        chk("reset_state", {30'd0, dbg_state}, 32'd0);
        chk("reset_vga", {14'd0, vga_x, vga_y, vga_colour}, 32'd0);
        reset = 1'b0;
        tick(1);

        // Full-screen sweep by the clear engine
        exp_grant_q.push_back(3'b001);
        req = 3'b001;
        tick(1);
        req = 3'b000;
        chk("sweep_busy", {31'd0, busy}, 32'd1);
        plot_cnt = 0;
        for (int y = 0; y < 120; y++) begin
            for (int x = 0; x < 160; x++) begin
                eng_x0 = 11'(x);
                eng_y0 = 11'(y);
                eng_colour0 = 3'(x ^ y);
                #2;
                if (plot) plot_cnt++;
                if (x == 37 && y == 91) begin
                    chk("sweep_vga_x", {24'd0, vga_x}, 32'd37);
                    chk("sweep_vga_y", {25'd0, vga_y}, 32'd91);
                    chk("sweep_vga_colour", {29'd0, vga_colour}, 32'd6);
                end
                tick(1);
            end
        end
        chk("sweep_draw_start", {29'd0, draw_start}, 32'd1);
        exp_end_q.push_back(4'b0001);
        eng_done = 3'b001;
        #2;
        chk("done_plot", {31'd0, plot}, 32'd0);
        tick(1);
        chk("release_draw_start", {29'd0, draw_start}, 32'd0);
        chk("release_busy", {31'd0, busy}, 32'd1);
        chk("release_state", {30'd0, dbg_state}, 32'd2);
        eng_done = 3'b000;
        tick(1);
        chk("busy_after_done", {31'd0, busy}, 32'd0);
        chk("plot_count", plot_cnt, 32'd19200);

        // Off-screen coordinates and truncation
        exp_grant_q.push_back(3'b001);
        req = 3'b001;
        tick(1);
        req = 3'b000;
        eng_x0 = 11'd160; eng_y0 = 11'd10; eng_colour0 = 3'd5;
        #2;
        chk("off_x_plot", {31'd0, plot}, 32'd0);
        chk("off_x_vga_x", {24'd0, vga_x}, 32'd160);
        chk("off_x_vga_y", {25'd0, vga_y}, 32'd10);
        chk("off_x_colour", {29'd0, vga_colour}, 32'd5);
        tick(1);
        eng_x0 = 11'd159; eng_y0 = 11'd119;
        #2;
        chk("corner_plot", {31'd0, plot}, 32'd1);
        tick(1);
        eng_x0 = 11'd3; eng_y0 = 11'd120;
        #2;
        chk("off_y_plot", {31'd0, plot}, 32'd0);
        chk("off_y_vga_y", {25'd0, vga_y}, 32'd120);
        tick(1);
        eng_x0 = 11'd300; eng_y0 = 11'd5;
        #2;
        chk("wide_x_plot", {31'd0, plot}, 32'd0);
        chk("wide_x_vga_x", {24'd0, vga_x}, 32'd44);
        tick(1);
        // Done from engines that do not own the port is ignored
        eng_done = 3'b110;
        tick(2);
        chk("ignore_state", {30'd0, dbg_state}, 32'd1);
        chk("ignore_draw_start", {29'd0, draw_start}, 32'd1);
        exp_end_q.push_back(4'b0001);
        eng_done = 3'b001;
        tick(1);
        eng_done = 3'b000;
        tick(1);

        // Round robin between sprite engines
        for (int k = 0; k < 4; k++) exp_grant_q.push_back(rr_exp[k]);
        req = 3'b110;
        for (int k = 0; k < 4; k++) begin
            wait_grant();
            tick(4);
            exp_end_q.push_back({1'b0, rr_exp[k]});
            eng_done = draw_start;
            tick(1);
            chk("rr_release_state", {30'd0, dbg_state}, 32'd2);
            eng_done = 3'b000;
            tick(1);
            chk("rr_idle_state", {30'd0, dbg_state}, 32'd0);
        end
        req = 3'b000;
        tick(1);

        // Clear request arriving mid-draw waits, then wins
        exp_grant_q.push_back(3'b010);
        req = 3'b010;
        wait_grant();
        req = 3'b111;
        tick(2);
        chk("preempt_state", {30'd0, dbg_state}, 32'd1);
        chk("preempt_draw_start", {29'd0, draw_start}, 32'd2);
        exp_end_q.push_back(4'b0010);
        exp_grant_q.push_back(3'b001);
        eng_done = 3'b010;
        tick(1);
        eng_done = 3'b000;
        tick(1);
        chk("preempt_idle", {30'd0, dbg_state}, 32'd0);
        tick(1);
        chk("preempt_next", {29'd0, draw_start}, 32'd1);
        req = 3'b000;
        exp_end_q.push_back(4'b0001);
        eng_done = 3'b001;
        tick(1);
        eng_done = 3'b000;
        tick(1);

        // Request dropped during a draw does not abort it
        exp_grant_q.push_back(3'b100);
        req = 3'b100;
        wait_grant();
        req = 3'b000;
        tick(3);
        chk("drop_req_state", {30'd0, dbg_state}, 32'd1);
        exp_end_q.push_back(4'b0100);
        eng_done = 3'b100;
        tick(1);
        eng_done = 3'b000;
        tick(1);

        // Watchdog expiry with no done
        exp_grant_q.push_back(3'b010);
        req = 3'b010;
        wait_grant();
        req = 3'b000;
        exp_end_q.push_back(4'b1000);
        n = -1;
        for (int i = 0; i < TO + 10; i++) begin
            if (timeout) begin
                n = i;
                break;
            end
            tick(1);
        end
        chk("timeout_cycle", n, TO - 1);
        chk("timeout_no_done", {29'd0, done_pulse}, 32'd0);
        tick(1);
        chk("timeout_draw_start", {29'd0, draw_start}, 32'd0);
        chk("timeout_release", {30'd0, dbg_state}, 32'd2);
        tick(1);
        chk("timeout_idle", {30'd0, dbg_state}, 32'd0);

        // Done on the watchdog's last cycle: done wins
        exp_grant_q.push_back(3'b100);
        req = 3'b110;
        wait_grant();
        req = 3'b000;
        exp_end_q.push_back(4'b0100);
        tick(TO - 1);
        eng_done = 3'b100;
        #2;
        chk("tie_timeout", {31'd0, timeout}, 32'd0);
        chk("tie_done_pulse", {29'd0, done_pulse}, 32'd4);
        tick(1);
        eng_done = 3'b000;
        tick(1);

        // Reset in the middle of a draw
        exp_grant_q.push_back(3'b010);
        req = 3'b010;
        wait_grant();
        req = 3'b000;
        tick(2);
        reset = 1'b1;
        eng_done = 3'b010;
        #2;
        chk("rst_no_done_pulse", {29'd0, done_pulse}, 32'd0);
        chk("rst_no_timeout", {31'd0, timeout}, 32'd0);
        tick(1);
        chk("rst_draw_start", {29'd0, draw_start}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        eng_done = 3'b000;
        exp_grant_q.push_back(3'b010);
        req = 3'b110;
        wait_grant();
        req = 3'b000;
        exp_end_q.push_back(4'b0010);
        eng_done = 3'b010;
        tick(1);
        eng_done = 3'b000;
        tick(3);

        chk("grant_queue_empty", exp_grant_q.size(), 32'd0);
        chk("strobe_queue_empty", exp_end_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/draw_scheduler.md
DRAW_SCHEDULER -- requirements
Module: draw_scheduler

Interface
REQ-001 Parameter: SCREEN_W, default 160, visible pixel columns.
REQ-002 Parameter: SCREEN_H, default 120, visible pixel rows.
REQ-003 Parameter: TIMEOUT, default 32768, maximum DRAW cycles per grant.
REQ-004 Port: clock  in  1  sole clock, all logic on rising edge.
REQ-005 Port: reset  in  1  synchronous, active-high reset.
REQ-006 Port: req  in  3  level draw requests; bit0 = clear engine, bit1/bit2 = sprite engines.
REQ-007 Port: eng_done  in  3  per-engine draw_done level.
REQ-008 Port: eng_colour0/1/2  in  3 each  engine pixel colour.
REQ-009 Port: eng_x0/1/2, eng_y0/1/2  in  11 each  engine pixel coordinates.
REQ-010 Port: draw_start  out  3  one-hot start level to engines.
REQ-011 Port: vga_x  out  8; vga_y  out  7; vga_colour  out  3  muxed pixel to VGA adapter.
REQ-012 Port: plot  out  1  VGA write enable.
REQ-013 Port: busy  out  1  high in any state except IDLE.
REQ-014 Port: done_pulse  out  3  one-cycle completion strobe per engine.
REQ-015 Port: timeout  out  1  one-cycle strobe on watchdog abort.

Function
REQ-016 The block shall implement FSM states IDLE, DRAW, RELEASE; a register grant[1:0] holds the owner.
REQ-017 In IDLE with req != 0, the block shall pick a winner and enter DRAW next edge: req[0] wins absolutely; else between bit1/bit2 round-robin, the one not served last wins when both set.
REQ-018 The round-robin pointer shall update only when engine 1 or 2 enters DRAW; clear grants shall not move it.
REQ-019 In DRAW, draw_start shall equal one-hot(grant) (registered); all other bits 0.
REQ-020 In DRAW, vga_x/vga_y/vga_colour shall combinationally mirror the granted engine's inputs, truncated to 8/7 bits.
REQ-021 plot shall be 1 only in DRAW when granted eng_done = 0, eng_x < SCREEN_W and eng_y < SCREEN_H (compare on full 11 bits before truncation); engines parking at x = 160 therefore never write.
REQ-022 Outside DRAW, vga_x = 0, vga_y = 0, vga_colour = 0, plot = 0.
REQ-023 In DRAW, when granted eng_done = 1, the block shall go to RELEASE, drop draw_start, and pulse done_pulse[grant] for exactly that transition cycle.
REQ-024 A 16-bit-minimum watchdog shall count DRAW cycles from 0 at entry; on reaching TIMEOUT-1 without done, the block shall go to RELEASE, pulse timeout, and not pulse done_pulse.
REQ-025 eng_done and watchdog expiry on the same cycle: done wins, timeout stays 0.
REQ-026 RELEASE shall hold draw_start = 0 until granted eng_done = 0, minimum one cycle, then return to IDLE.
REQ-027 A new grant shall never occur from RELEASE; minimum gap between grants is 2 cycles (RELEASE, IDLE).
REQ-028 Requests deasserted during DRAW shall not abort the draw; req is sampled only in IDLE.
REQ-029 eng_done of non-granted engines shall be ignored.

Reset
REQ-030 Reset shall force state IDLE, grant 0, round-robin pointer favouring engine 1, watchdog 0, draw_start 0, done_pulse 0, timeout 0, busy 0, plot 0.
REQ-031 Reset asserted mid-DRAW shall drop draw_start on the next edge with no done_pulse or timeout strobe.

Verification
REQ-032 req=001, engine 0 sweeps 160x120 then done -> draw_start=001, 19200 plot cycles, done_pulse=001 once, busy low 2 cycles after done.
REQ-033 req=110 held, engines done after 5 cycles each -> grants alternate 1,2,1,2; never same engine twice consecutively.
REQ-034 req=111 during engine-1 DRAW -> engine 1 finishes; next grant engine 0.
REQ-035 eng_x0=160 while drawing -> plot=0, vga pixel still mirrored.
REQ-036 TIMEOUT=16, engine never signals done -> timeout strobe on 16th DRAW cycle, draw_start drops, no done_pulse.
REQ-037 reset high at DRAW cycle 3 -> next edge draw_start=000, busy=0, then fresh arbitration with pointer at engine 1.
